inst_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and issues word requests to instruction memory over a valid/ready channel. Returned instructions are buffered in a small in-order queue and presented to decode with their PC and PC+4; decode slices opcode/rt/funct from the word. Redirects from branch/jump resolution flush in-flight fetches, and a halt from syscall-exit freezes fetch.

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch_queue.sv | 55 +++++
 rtl/inst_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants, state encoding and PC helpers for inst_fetch_unit.
package inst_fetch_pkg;

  localparam int unsigned INST_W             = 32;
  localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam int unsigned IBUF_DEPTH_DEFAULT = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// In-order {pc, instr} buffer between instruction memory and decode; flush empties it.
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only observed once counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses for decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module inst_fetch_unit
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic [31:0]       inst_pc4,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
);

  localparam int unsigned AW = $clog2(IBUF_DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_q_count;
  logic [CW:0]   w_inflight;
  logic [31:0]   r_pq [IBUF_DEPTH];
  logic [AW-1:0] r_pq_wr;
  logic [AW-1:0] r_pq_rd;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_q_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  // Credits cover both in-flight requests and buffered words, so the queue can never overflow.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign imem_req_valid = rst_n && (r_state == ST_RUN) && !halt && !redirect_valid &&
                          (w_inflight < (CW+1)'(IBUF_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);
  assign w_pop          = inst_valid && inst_ready;
  assign w_push_entry   = '{pc: r_pq[r_pq_rd], instr: imem_resp_data};

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      ST_RUN:  if (halt) w_state_next = ST_HALT;
      ST_HALT: if (!halt && redirect_valid) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
    if (redirect_valid)  w_pc_next = pc_align(redirect_pc);
    else if (w_accept)   w_pc_next = pc_next(r_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Stale responses keep popping the PC queue so it stays aligned with the memory's order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_pq_wr       <= '0;
      r_pq_rd       <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
      if (redirect_valid)
        r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
      else if (imem_resp_valid && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - 1'b1;
      if (w_accept)        r_pq_wr <= r_pq_wr + 1'b1;
      if (imem_resp_valid) r_pq_rd <= r_pq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pq[r_pq_wr] <= r_pc;
  end

  inst_fetch_queue #(.DEPTH(IBUF_DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_head       (w_head),
    .o_empty      (w_q_empty),
    .o_count      (w_q_count)
  );

  assign inst_valid = !w_q_empty;
  assign inst_data  = inst_valid ? w_head.instr : '0;
  assign inst_pc    = inst_valid ? w_head.pc : '0;
  assign inst_pc4   = pc_next(inst_pc);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_pop && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (inst_ready && !inst_valid && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: memory model plus an architectural PC-stream reference.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always #5 clk = ~clk;

  inst_fetch_unit #(.PC_RESET(32'h0000_3000), .IBUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc4        (inst_pc4),
    .fetch_cnt       (fetch_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  int          checksTotal = 0;
  int          checksPassed = 0;
  int          cyc = 0;
  int          sinceReset = 0;
  int          acceptedSinceReset = 0;
  int          deliveredSinceReset = 0;
  int          bubblesSinceReset = 0;
  logic [31:0] expFetchPc = 32'h3000;
  logic [31:0] expDeliverPc = 32'h3000;
  bit          haltState = 0;
  bit          needRelease = 0;
  int          memLat = 1;
  bit          memLatRandom = 0;
  int          memReadyPct = 100;
  int          instReadyPct = 100;
  int          randRedirPct = 0;
  int          randHaltPct = 0;
  bit          haltDrive = 0;
  bit          redirDrive = 0;
  logic [31:0] redirTarget = '0;
  bit          armRedirOnRespPop = 0;
  bit          redirHit = 0;
  bit          armHalt = 0;
  logic [31:0] haltAtAddr = '0;
  bit          sawZeroAddr = 0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    haltDrive = 0;
    redirDrive = 0;
    #1;
    checkOutput("rstReqValid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rstReqAddr", imem_req_addr, 32'h0000_3000);
    checkOutput("rstInstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rstInstData", inst_data, 32'd0);
    checkOutput("rstInstPc", inst_pc, 32'd0);
    checkOutput("rstInstPc4", inst_pc4, 32'd4);
    checkOutput("rstFetchCnt", fetch_cnt, 32'd0);
    checkOutput("rstBubbleCnt", bubble_cnt, 32'd0);
    repeat (2) @(negedge clk);
    memQ.delete();
    expFetchPc = 32'h3000;
    expDeliverPc = 32'h3000;
    haltState = 0;
    acceptedSinceReset = 0;
    deliveredSinceReset = 0;
    bubblesSinceReset = 0;
    sinceReset = 0;
    needRelease = 1;
  endtask

  // One clock cycle: drive at the falling edge, then observe and advance the reference model.
  task automatic applyStimulus();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    if (needRelease) begin
      rst_n = 1'b1;
      needRelease = 0;
    end
    sinceReset++;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < memReadyPct);
    inst_ready = ($urandom_range(99) < instReadyPct);
    if (randHaltPct > 0 && $urandom_range(99) < randHaltPct) haltDrive = !haltDrive;
    halt = haltDrive;
    redirect_valid = redirDrive;
    redirect_pc = redirTarget;
    if (randRedirPct > 0 && $urandom_range(99) < randRedirPct) begin
      redirect_valid = 1'b1;
      redirect_pc = $urandom;
    end
    redirDrive = 0;
    #1;
    if (armRedirOnRespPop && imem_resp_valid && inst_valid && inst_ready) begin
      redirect_valid = 1'b1;
      redirect_pc = redirTarget;
      armRedirOnRespPop = 0;
      redirHit = 1;
    end
    if (armHalt && imem_req_addr == haltAtAddr) begin
      halt = 1'b1;
      haltDrive = 1;
      armHalt = 0;
    end
    #1;
    if (haltState || halt || redirect_valid)
      checkOutput("reqBlocked", {31'd0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      checkOutput("reqAddr", imem_req_addr, expFetchPc);
      lat = memLatRandom ? int'($urandom_range(3, 1)) : memLat;
      due = cyc + lat;
      if (memQ.size() > 0 && due < memQ[$].due) due = memQ[$].due;
      memQ.push_back('{addr: imem_req_addr, due: due});
      if (imem_req_addr == 32'd0) sawZeroAddr = 1;
      expFetchPc = expFetchPc + 32'd4;
      acceptedSinceReset++;
    end
    if (inst_valid && inst_ready) begin
      checkOutput("instPc", inst_pc, expDeliverPc);
      checkOutput("instData", inst_data, memWord(expDeliverPc));
      checkOutput("instPc4", inst_pc4, expDeliverPc + 32'd4);
      expDeliverPc = expDeliverPc + 32'd4;
      deliveredSinceReset++;
    end
    if (inst_ready && !inst_valid) bubblesSinceReset++;
    if (redirect_valid) begin
      expFetchPc = {redirect_pc[31:2], 2'b00};
      expDeliverPc = {redirect_pc[31:2], 2'b00};
    end
    if (halt) haltState = 1;
    else if (redirect_valid) haltState = 0;
  endtask

  task automatic checkCounters(input string tag);
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, "Fetch"}, fetch_cnt, deliveredSinceReset);
    checkOutput({tag, "Bubble"}, bubble_cnt, bubblesSinceReset);
`else
    checkOutput({tag, "Fetch"}, fetch_cnt, 32'd0);
    checkOutput({tag, "Bubble"}, bubble_cnt, 32'd0);
`endif
  endtask

  initial begin
    int base;
    int n;

    // Startup and throughput with a 1-cycle memory.
    doReset();
    memLat = 1;
    for (int i = 1; i <= 23; i++) begin
      applyStimulus();
      if (i == 1) checkOutput("firstReq", {31'd0, imem_req_valid}, 32'd1);
      if (i <= 3) checkOutput("startValid", {31'd0, inst_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("throughput", deliveredSinceReset, 32'd21);

    // Decode stall: credits must cap buffered plus in-flight words at the queue depth.
    instReadyPct = 0;
    repeat (10) applyStimulus();
    checkOutput("stallInflight", acceptedSinceReset - deliveredSinceReset, DEPTH);
    checkOutput("stallNoReq", {31'd0, imem_req_valid}, 32'd0);
    instReadyPct = 100;
    repeat (12) applyStimulus();
    checkCounters("cntStartup");

    // Redirect with two requests outstanding on a 3-cycle memory.
    memLat = 3;
    memReadyPct = 0;
    for (int i = 0; i < 12 && memQ.size() > 0; i++) applyStimulus();
    checkOutput("memDrain", memQ.size(), 32'd0);
    memReadyPct = 100;
    base = acceptedSinceReset;
    for (int i = 0; i < 12 && (acceptedSinceReset - base) < 2; i++) applyStimulus();
    checkOutput("twoIssued", acceptedSinceReset - base, 32'd2);
    memReadyPct = 0;
    redirDrive = 1;
    redirTarget = 32'h0000_4000;
    applyStimulus();
    memReadyPct = 100;
    base = deliveredSinceReset;
    repeat (15) applyStimulus();
    checkOutput("postRedirFlow", {31'd0, (deliveredSinceReset - base) >= 5}, 32'd1);

    // Redirect coinciding with a response and a pop.
    memLat = 1;
    repeat (6) applyStimulus();
    redirTarget = 32'h0000_5000;
    redirHit = 0;
    armRedirOnRespPop = 1;
    for (int i = 0; i < 10 && !redirHit; i++) applyStimulus();
    checkOutput("coincideHit", {31'd0, redirHit}, 32'd1);
    armRedirOnRespPop = 0;
    applyStimulus();
    checkOutput("emptyAfterRedir", {31'd0, inst_valid}, 32'd0);
    repeat (6) applyStimulus();

    // Mid-run reset, then halt at 0x3010 and resume by redirect.
    doReset();
    haltAtAddr = 32'h0000_3010;
    armHalt = 1;
    repeat (12) applyStimulus();
    checkOutput("haltArmed", {31'd0, armHalt}, 32'd0);
    haltDrive = 0;
    repeat (3) applyStimulus();
    redirDrive = 1;
    redirTarget = 32'h0000_3100;
    applyStimulus();
    base = acceptedSinceReset;
    repeat (8) applyStimulus();
    checkOutput("resumed", {31'd0, acceptedSinceReset > base}, 32'd1);
    haltDrive = 1;
    redirDrive = 1;
    redirTarget = 32'h0000_3200;
    repeat (3) applyStimulus();
    haltDrive = 0;
    repeat (3) applyStimulus();
    redirDrive = 1;
    redirTarget = 32'h0000_3300;
    repeat (8) applyStimulus();

    // PC wrap at the top of the address space.
    redirDrive = 1;
    redirTarget = 32'hFFFF_FFF8;
    sawZeroAddr = 0;
    repeat (10) applyStimulus();
    checkOutput("wrapToZero", {31'd0, sawZeroAddr}, 32'd1);
    checkCounters("cntHalt");

    // Random traffic: latency, backpressure, redirects and halts.
    memLatRandom = 1;
    memReadyPct = 70;
    instReadyPct = 70;
    randRedirPct = 4;
    randHaltPct = 3;
    repeat (800) applyStimulus();
    randRedirPct = 0;
    randHaltPct = 0;
    haltDrive = 0;
    memReadyPct = 100;
    instReadyPct = 100;
    redirDrive = 1;
    redirTarget = 32'h0000_6000;
    base = deliveredSinceReset;
    repeat (25) applyStimulus();
    checkOutput("randomResume", {31'd0, (deliveredSinceReset - base) >= 10}, 32'd1);
    checkCounters("cntFinal");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
